mpmc9_rcache_fill: RTL and testbench

//  Write-side feeder for the mpmc9 eight-port read cache. Takes 128-bit line fills returned by the DRAM read path
//  and write-address snoops from all channels. Drives the cache's wr/wadr/wdat/inv write port on wclk.

---
 rtl/mpmc9_rcache_fill_pkg.sv | 19 +
 rtl/mpmc9_rcache_fill_if.sv | 29 ++
 rtl/mpmc9_rcache_fill_fifo.sv | 82 ++++++++
 rtl/mpmc9_rcache_fill.sv | 172 +++++++++++++++++
 tb/tb_mpmc9_rcache_fill.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpmc9_rcache_fill_pkg.sv
// Shared types and constants for the mpmc9 read-cache fill feeder.
//   rcache_fill_t        : one queued fill (line tag, line data, kill flag)
//   rcache_fill_state_t  : feeder FSM states (RUN / FLUSH sweep)
//   RCACHE_LINES         : default number of cache lines (index = adr[13:4])
//   RCACHE_FIFO_DEPTH    : default fill queue depth
package mpmc9_rcache_fill_pkg;

  localparam int unsigned RCACHE_LINES      = 1024;
  localparam int unsigned RCACHE_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [27:0]  tag;
    logic [127:0] dat;
    logic         kill;
  } rcache_fill_t;

  typedef enum logic {RCF_RUN, RCF_FLUSH} rcache_fill_state_t;

endpackage

// File: rtl/mpmc9_rcache_fill_if.sv
// Bus bundle between the DRAM read path / channel snoops and the cache
// write port.
//   fill_v/fill_adr/fill_dat/fill_rdy : 128-bit line fill handshake
//   snoop_v/snoop_adr/snoop_rdy       : committed channel write snoop
//   wr/wadr/wdat/inv                  : cache write port (registered)
// Modports: master = traffic source / cache side, slave = the feeder.
interface mpmc9_rcache_fill_if;
  logic         fill_v;
  logic [31:0]  fill_adr;
  logic [127:0] fill_dat;
  logic         fill_rdy;
  logic         snoop_v;
  logic [31:0]  snoop_adr;
  logic         snoop_rdy;
  logic         wr;
  logic [31:0]  wadr;
  logic [127:0] wdat;
  logic         inv;

  modport master (
    output fill_v, fill_adr, fill_dat, snoop_v, snoop_adr,
    input  fill_rdy, snoop_rdy, wr, wadr, wdat, inv
  );

  modport slave (
    input  fill_v, fill_adr, fill_dat, snoop_v, snoop_adr,
    output fill_rdy, snoop_rdy, wr, wadr, wdat, inv
  );
endinterface

// File: rtl/mpmc9_rcache_fill_fifo.sv
// Fill queue for the read-cache feeder.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : enqueue one fill (ignored when full)
//   pop               : dequeue head (ignored when empty)
//   kill_v, kill_tag  : mark every valid entry (and a same-cycle push) with a
//                       matching tag as killed
//   kill_all          : mark every valid entry (and a same-cycle push) killed
//   head              : current head entry
//   empty, full       : occupancy flags
module mpmc9_rcache_fill_fifo
  import mpmc9_rcache_fill_pkg::*;
#(
  parameter int unsigned DEPTH = RCACHE_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  rcache_fill_t push_data,
  input  logic         pop,
  input  logic         kill_v,
  input  logic [27:0]  kill_tag,
  input  logic         kill_all,
  output rcache_fill_t head,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);

  rcache_fill_t   mem_q [DEPTH];
  rcache_fill_t   mem_d [DEPTH];
  logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [AW-1:0]  off;
  logic           push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign head    = mem_q[rp_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    off   = '0;
    // Slot i is occupied when its distance from the read pointer is below the count.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rp_q;
      if (({1'b0, off} < cnt_q) &&
          (kill_all || (kill_v && (mem_q[i].tag == kill_tag)))) begin
        mem_d[i].kill = 1'b1;
      end
    end
    if (push_ok) begin
      mem_d[wp_q]      = push_data;
      mem_d[wp_q].kill = push_data.kill || kill_all ||
                         (kill_v && (push_data.tag == kill_tag));
      wp_d             = wp_q + 1'b1;
    end
    if (pop_ok) begin
      rp_d = rp_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mpmc9_rcache_fill.sv
// Write-side feeder for the mpmc9 eight-port read cache. Queues line fills,
// snoops committed channel writes and drives the cache write port so that a
// queued fill never re-validates a line a later write has made stale.
//   wclk, rst    : clock (shared with cache write port), sync active-high reset
//   bus (slave)  : fill handshake, snoop handshake, wr/wadr/wdat/inv outputs
//   busy         : queue non-empty, snoop pending or sweep in progress
//   flush        : (MPMC9_RCACHE_FLUSH_EN) request a full invalidate sweep
//   flush_busy   : (MPMC9_RCACHE_FLUSH_EN) sweep in progress
// Optional feature macro: MPMC9_RCACHE_FLUSH_EN.
module mpmc9_rcache_fill
  import mpmc9_rcache_fill_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = RCACHE_FIFO_DEPTH,
  parameter int unsigned LINES      = RCACHE_LINES
) (
  input  logic               wclk,
  input  logic               rst,
  mpmc9_rcache_fill_if.slave bus,
  output logic               busy
`ifdef MPMC9_RCACHE_FLUSH_EN
  ,
  input  logic               flush,
  output logic               flush_busy
`endif
);

  logic         snoop_pend_q, snoop_pend_d;
  logic [27:0]  snoop_line_q, snoop_line_d;
  logic         wr_q, wr_d, inv_q, inv_d;
  logic [31:0]  wadr_q, wadr_d;
  logic [127:0] wdat_q, wdat_d;

  logic         snoop_acc, push, pop, head_kill;
  logic         fifo_empty, fifo_full;
  logic [27:0]  snoop_tag;
  rcache_fill_t head, push_data;
  logic         flush_start, in_flush;
  logic [31:0]  sweep_adr;
  logic         unused_lsbs;

  assign unused_lsbs = ^{bus.fill_adr[3:0], bus.snoop_adr[3:0]};

  assign snoop_tag = bus.snoop_adr[31:4];
  assign snoop_acc = bus.snoop_v && !snoop_pend_q;
  assign push      = bus.fill_v && !fifo_full;
  assign push_data = '{tag: bus.fill_adr[31:4], dat: bus.fill_dat, kill: 1'b0};
  // A snoop accepted this cycle must also stop the head being written now.
  assign head_kill = head.kill || (snoop_acc && (head.tag == snoop_tag));

  mpmc9_rcache_fill_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (wclk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .kill_v    (snoop_acc),
    .kill_tag  (snoop_tag),
    .kill_all  (flush_start),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef MPMC9_RCACHE_FLUSH_EN
  localparam int unsigned IDXW = $clog2(LINES);

  rcache_fill_state_t state_q, state_d;
  logic [IDXW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= RCF_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RCF_RUN: begin
        if (flush) begin
          state_d = RCF_FLUSH;
          cnt_d   = '0;
        end
      end
      RCF_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDXW'(LINES - 1)) begin
          state_d = RCF_RUN;
        end
      end
      default: state_d = RCF_RUN;
    endcase
  end

  assign flush_start = (state_q == RCF_RUN) && flush;
  assign in_flush    = (state_q == RCF_FLUSH);
  assign flush_busy  = in_flush;
  assign sweep_adr   = {{(28-IDXW){1'b0}}, cnt_q, 4'h0};
`else
  logic [31:0] unused_lines;

  assign unused_lines = 32'(LINES);
  assign flush_start  = 1'b0;
  assign in_flush     = 1'b0;
  assign sweep_adr    = '0;
`endif

  // Output arbiter: sweep, then pending snoop, then queue head.
  always_comb begin
    wr_d         = 1'b0;
    inv_d        = 1'b0;
    wadr_d       = wadr_q;
    wdat_d       = wdat_q;
    pop          = 1'b0;
    snoop_pend_d = snoop_pend_q;
    snoop_line_d = snoop_line_q;
    if (snoop_acc) begin
      snoop_pend_d = 1'b1;
      snoop_line_d = snoop_tag;
    end
    if (in_flush) begin
      inv_d  = 1'b1;
      wadr_d = sweep_adr;
    end else if (flush_start) begin
      // Sweep entry cycle: queue is being killed, pending snoop waits.
      inv_d = 1'b0;
    end else if (snoop_pend_q) begin
      inv_d        = 1'b1;
      wadr_d       = {snoop_line_q, 4'h0};
      snoop_pend_d = 1'b0;
    end else if (!fifo_empty) begin
      pop = 1'b1;
      if (!head_kill) begin
        wr_d   = 1'b1;
        wadr_d = {head.tag, 4'h0};
        wdat_d = head.dat;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      snoop_pend_q <= 1'b0;
      snoop_line_q <= '0;
      wr_q         <= 1'b0;
      inv_q        <= 1'b0;
      wadr_q       <= '0;
      wdat_q       <= '0;
    end else begin
      snoop_pend_q <= snoop_pend_d;
      snoop_line_q <= snoop_line_d;
      wr_q         <= wr_d;
      inv_q        <= inv_d;
      wadr_q       <= wadr_d;
      wdat_q       <= wdat_d;
    end
  end

  assign bus.fill_rdy  = !fifo_full;
  assign bus.snoop_rdy = !snoop_pend_q;
  assign bus.wr        = wr_q;
  assign bus.inv       = inv_q;
  assign bus.wadr      = wadr_q;
  assign bus.wdat      = wdat_q;
  assign busy          = !fifo_empty || snoop_pend_q || in_flush;

endmodule

// File: tb/tb_mpmc9_rcache_fill.sv
// Self-checking bench for mpmc9_rcache_fill: reset state, single fill latency,
// full queue under snoop stalls, snoop kill of queued/head fills, same-cycle
// fill+snoop, optional flush sweep, and reset while busy.
module tb_mpmc9_rcache_fill;
  import mpmc9_rcache_fill_pkg::*;

  typedef struct packed {
    logic [31:0]  adr;
    logic [127:0] dat;
  } wr_t;

  localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic wclk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  logic [31:0] exp_inv[$];
  logic [31:0] obs_inv[$];
  logic        both_seen;
  int          fb_cycles;

  mpmc9_rcache_fill_if bus ();

`ifdef MPMC9_RCACHE_FLUSH_EN
  logic flush;
  logic flush_busy;
`endif

  mpmc9_rcache_fill #(.FIFO_DEPTH(4), .LINES(1024)) dut (
    .wclk       (wclk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy)
`ifdef MPMC9_RCACHE_FLUSH_EN
    ,
    .flush      (flush),
    .flush_busy (flush_busy)
`endif
  );

  always #5 wclk = ~wclk;

  // Advance one clock and record what the cache write port did on that edge.
  task automatic step();
    @(posedge wclk);
    #1;
    if (bus.wr === 1'b1) obs_wr.push_back({bus.wadr, bus.wdat});
    if (bus.inv === 1'b1) obs_inv.push_back(bus.wadr);
    if (bus.wr === 1'b1 && bus.inv === 1'b1) both_seen = 1'b1;
`ifdef MPMC9_RCACHE_FLUSH_EN
    if (flush_busy === 1'b1) fb_cycles++;
`endif
  endtask

  task automatic idle_inputs();
    bus.fill_v    = 1'b0;
    bus.fill_adr  = '0;
    bus.fill_dat  = '0;
    bus.snoop_v   = 1'b0;
    bus.snoop_adr = '0;
`ifdef MPMC9_RCACHE_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic clear_sb();
    exp_wr.delete();
    obs_wr.delete();
    exp_inv.delete();
    obs_inv.delete();
    both_seen = 1'b0;
    fb_cycles = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear_sb();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({bus.wr, bus.inv, bus.fill_rdy, bus.snoop_rdy, busy} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_ctrl: wr,inv,fill_rdy,snoop_rdy,busy got %b expected 00110",
               {bus.wr, bus.inv, bus.fill_rdy, bus.snoop_rdy, busy});
    end
    checks++;
    if (bus.wadr !== 32'h0) begin
      errors++;
      $display("FAIL reset_wadr: got %h expected 0", bus.wadr);
    end
    checks++;
    if (bus.wdat !== 128'h0) begin
      errors++;
      $display("FAIL reset_wdat: got %h expected 0", bus.wdat);
    end
`ifdef MPMC9_RCACHE_FLUSH_EN
    checks++;
    if (flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_busy: got %b expected 0", flush_busy);
    end
`endif
  endtask

  task automatic test_single_fill();
    clear_sb();
    bus.fill_v   = 1'b1;
    bus.fill_adr = 32'h0001_2340;
    bus.fill_dat = D1;
    step();
    bus.fill_v = 1'b0;
    checks++;
    if (bus.wr !== 1'b0) begin
      errors++;
      $display("FAIL t1_wr_early: got %b expected 0", bus.wr);
    end
    step();
    checks++;
    if (bus.wr !== 1'b1 || bus.inv !== 1'b0) begin
      errors++;
      $display("FAIL t1_wr_pulse: wr=%b inv=%b expected wr=1 inv=0", bus.wr, bus.inv);
    end
    checks++;
    if (bus.wadr !== 32'h0001_2340) begin
      errors++;
      $display("FAIL t1_wadr: got %h expected 00012340", bus.wadr);
    end
    checks++;
    if (bus.wdat !== D1) begin
      errors++;
      $display("FAIL t1_wdat: got %h expected %h", bus.wdat, D1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy: got %b expected 0", busy);
    end
    step();
    checks++;
    if (bus.wr !== 1'b0 || bus.wdat !== D1) begin
      errors++;
      $display("FAIL t1_hold: wr=%b wdat=%h expected wr=0 wdat=%h", bus.wr, bus.wdat, D1);
    end
  endtask

  task automatic test_fifo_full();
    int nf = 0;
    int ns = 0;
    bit saw_full = 1'b0;
    logic [127:0] d;
    clear_sb();
    for (int c = 0; c < 40 && !saw_full; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      bus.fill_v    = 1'b1;
      bus.fill_adr  = 32'h1000_0000 + 32'(nf << 4);
      bus.fill_dat  = d;
      bus.snoop_v   = 1'b1;
      bus.snoop_adr = 32'h8000_0000 + 32'(ns << 4);
      if (bus.fill_rdy === 1'b1) begin
        exp_wr.push_back({32'h1000_0000 + 32'(nf << 4), d});
        nf++;
      end else begin
        saw_full = 1'b1;
        checks++;
        if (nf - obs_wr.size() != 4) begin
          errors++;
          $display("FAIL t2_full_level: fill_rdy low with %0d entries expected 4",
                   nf - obs_wr.size());
        end
      end
      if (bus.snoop_rdy === 1'b1) begin
        exp_inv.push_back(32'h8000_0000 + 32'(ns << 4));
        ns++;
      end
      step();
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL t2_saw_full: fill_rdy never low got 0 expected 1");
    end
    idle_inputs();
    repeat (16) step();
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL t2_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o;
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t2_wr_order: got %h/%h expected %h/%h", o.adr, o.dat, e.adr, e.dat);
      end
    end
    checks++;
    if (obs_inv.size() != exp_inv.size()) begin
      errors++;
      $display("FAIL t2_inv_count: got %0d expected %0d", obs_inv.size(), exp_inv.size());
    end
    while (exp_inv.size() > 0 && obs_inv.size() > 0) begin
      logic [31:0] e, o;
      e = exp_inv.pop_front();
      o = obs_inv.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t2_inv_order: got %h expected %h", o, e);
      end
    end
    checks++;
    if (both_seen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t2_idle: wr&inv=%b busy=%b expected 0 0", both_seen, busy);
    end
  endtask

  task automatic test_snoop_kill();
    logic [127:0] d;
    clear_sb();
    // Head fill A killed by a snoop accepted in its pop cycle.
    bus.fill_v   = 1'b1;
    bus.fill_adr = 32'h0002_0040;
    bus.fill_dat = 128'hA;
    step();
    bus.fill_v    = 1'b0;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h0002_004C;
    exp_inv.push_back(32'h0002_0040);
    step();
    bus.snoop_v = 1'b0;
    step();
    step();
    // Fill B afterwards is written normally.
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.fill_v   = 1'b1;
    bus.fill_adr = 32'h0003_0080;
    bus.fill_dat = d;
    exp_wr.push_back({32'h0003_0080, d});
    step();
    bus.fill_v = 1'b0;
    step();
    step();
    // Fill A2 queued behind P is killed while not at the head.
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.fill_v    = 1'b1;
    bus.fill_adr  = 32'h0004_0100;
    bus.fill_dat  = d;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h0009_0000;
    exp_wr.push_back({32'h0004_0100, d});
    exp_inv.push_back(32'h0009_0000);
    step();
    bus.snoop_v  = 1'b0;
    bus.fill_adr = 32'h0005_0200;
    bus.fill_dat = 128'hBAD;
    step();
    bus.fill_v    = 1'b0;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h0005_0208;
    exp_inv.push_back(32'h0005_0200);
    step();
    bus.snoop_v = 1'b0;
    repeat (6) step();
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL t3_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o;
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t3_wr: got %h/%h expected %h/%h", o.adr, o.dat, e.adr, e.dat);
      end
    end
    checks++;
    if (obs_inv.size() != exp_inv.size()) begin
      errors++;
      $display("FAIL t3_inv_count: got %0d expected %0d", obs_inv.size(), exp_inv.size());
    end
    while (exp_inv.size() > 0 && obs_inv.size() > 0) begin
      logic [31:0] e, o;
      e = exp_inv.pop_front();
      o = obs_inv.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t3_inv: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_same_cycle();
    clear_sb();
    bus.fill_v    = 1'b1;
    bus.fill_adr  = 32'h0006_0305;
    bus.fill_dat  = 128'h5A5A;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h0006_0300;
    exp_inv.push_back(32'h0006_0300);
    step();
    idle_inputs();
    repeat (6) step();
    checks++;
    if (obs_wr.size() != 0) begin
      errors++;
      $display("FAIL t4_no_wr: got %0d writes expected 0", obs_wr.size());
    end
    checks++;
    if (obs_inv.size() != 1) begin
      errors++;
      $display("FAIL t4_inv_count: got %0d expected 1", obs_inv.size());
    end
    while (exp_inv.size() > 0 && obs_inv.size() > 0) begin
      logic [31:0] e, o;
      e = exp_inv.pop_front();
      o = obs_inv.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t4_inv: got %h expected %h", o, e);
      end
    end
    checks++;
    if (busy !== 1'b0 || both_seen !== 1'b0) begin
      errors++;
      $display("FAIL t4_idle: busy=%b wr&inv=%b expected 0 0", busy, both_seen);
    end
  endtask

`ifdef MPMC9_RCACHE_FLUSH_EN
  task automatic test_flush();
    clear_sb();
    bus.fill_v    = 1'b1;
    bus.fill_adr  = 32'h0007_0010;
    bus.fill_dat  = 128'h1;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h0008_0020;
    step();
    bus.snoop_v  = 1'b0;
    bus.fill_adr = 32'h0007_0020;
    bus.fill_dat = 128'h2;
    flush        = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 1024; i++) exp_inv.push_back(32'(i << 4));
    exp_inv.push_back(32'h0008_0020);
    repeat (1030) step();
    checks++;
    if (fb_cycles != 1024) begin
      errors++;
      $display("FAIL t5_flush_busy_cycles: got %0d expected 1024", fb_cycles);
    end
    checks++;
    if (obs_wr.size() != 0) begin
      errors++;
      $display("FAIL t5_no_wr: got %0d writes expected 0", obs_wr.size());
    end
    checks++;
    if (obs_inv.size() != exp_inv.size()) begin
      errors++;
      $display("FAIL t5_inv_count: got %0d expected %0d", obs_inv.size(), exp_inv.size());
    end
    while (exp_inv.size() > 0 && obs_inv.size() > 0) begin
      logic [31:0] e, o;
      e = exp_inv.pop_front();
      o = obs_inv.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t5_inv: got %h expected %h", o, e);
      end
    end
    checks++;
    if (flush_busy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_end: flush_busy=%b busy=%b expected 0 0", flush_busy, busy);
    end
  endtask
`endif

  task automatic test_reset_busy();
    clear_sb();
    bus.fill_v    = 1'b1;
    bus.fill_adr  = 32'h000A_0000;
    bus.fill_dat  = 128'h11;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h000B_0000;
    step();
    bus.snoop_v  = 1'b0;
    bus.fill_adr = 32'h000A_0010;
    step();
    bus.fill_adr  = 32'h000A_0020;
    bus.snoop_v   = 1'b1;
    bus.snoop_adr = 32'h000B_0010;
    step();
    bus.snoop_v = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.snoop_rdy !== 1'b0) begin
      errors++;
      $display("FAIL t6_pre: busy=%b snoop_rdy=%b expected 1 0", busy, bus.snoop_rdy);
    end
    obs_wr.delete();
    obs_inv.delete();
    bus.fill_adr = 32'h000A_0030;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.wr, bus.inv, bus.fill_rdy, bus.snoop_rdy, busy} !== 5'b00110) begin
      errors++;
      $display("FAIL t6_after_reset: wr,inv,fill_rdy,snoop_rdy,busy got %b expected 00110",
               {bus.wr, bus.inv, bus.fill_rdy, bus.snoop_rdy, busy});
    end
    idle_inputs();
    repeat (6) step();
    checks++;
    if (obs_wr.size() != 0 || obs_inv.size() != 0) begin
      errors++;
      $display("FAIL t6_dropped: got %0d wr %0d inv expected 0 0", obs_wr.size(), obs_inv.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fill();
    test_fifo_full();
    test_snoop_kill();
    test_same_cycle();
`ifdef MPMC9_RCACHE_FLUSH_EN
    test_flush();
`endif
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
